vga_pixel_fetch: RTL and testbench

Pixel fetch stage directly downstream of the VGA timing generator. Consumes its `h_sync`, `v_sync` and `bright` outputs, generates sequential read addresses into a 160x120 RGB332 framebuffer (external synchronous RAM, 1-cycle read latency), and drives 4-bit-per-channel colour plus delayed syncs to the DAC/pins. Sync and colour leave the block mutually aligned with a fixed 2-cycle latency.

---
 rtl/vga_pixel_fetch.sv | 189 ++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Purpose : pixel fetch stage behind the VGA timing generator; reads a 160x120 RGB332
//           framebuffer sequentially and drives 4-bit colour plus delayed syncs.
// Latency : syncs and colour leave 2 clock edges after h_sync_in/v_sync_in/bright_in.
// Backpressure: none; this is a free-running video pipe paced by bright_in.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_mode input and an
// 8-bar colour pattern that replaces framebuffer data when test_mode=1.
//
// Ports:
//   clk_25                pixel clock (single domain)
//   reset                 synchronous, active-high reset
//   h_sync_in, v_sync_in  active-low syncs from the timing generator
//   bright_in             active-window flag from the timing generator
//   fb_rd_en, fb_addr     framebuffer read strobe and address (registered)
//   fb_data               RGB332 pixel, valid the cycle after fb_rd_en
//   vga_r/g/b             4-bit colour, forced to 0 outside the active window
//   h_sync, v_sync        syncs delayed to line up with colour
//   frame_done            one-cycle pulse when the last framebuffer pixel is fetched
//   line_err              sticky flag: some line had active length != H_RES
//   test_mode             colour-bar select (VGA_TEST_PATTERN_EN builds only)
module vga_pixel_fetch #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              bright_in,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              h_sync,
    output logic              v_sync,
    output logic              frame_done,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              line_err
);

    localparam int                FRAME_PIX = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        X_LINE    = 8'(H_RES);

    // Fetch-side state
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        x_q, x_d;
    logic              bright_q;
    logic              v_sync_q;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;

    // Two-stage delay lines that keep syncs and blanking aligned with fb_data
    logic              hs_d1_q, hs_d2_q;
    logic              vs_d1_q, vs_d2_q;
    logic              br_d1_q, br_d2_q;

    logic              vs_fall;

    assign vs_fall = v_sync_q & ~v_sync_in;

    always_comb begin
        addr_d       = addr_q;
        x_d          = x_q;
        rd_en_d      = bright_in;
        fb_addr_d    = fb_addr_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;

        if (bright_in) begin
            fb_addr_d = addr_q;
            // Saturate so an overlong line can never wrap back to a legal length.
            if (x_q != 8'hFF) begin
                x_d = x_q + 8'd1;
            end
            if (addr_q == LAST_ADDR) begin
                addr_d       = '0;
                frame_done_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_ONE;
            end
        end

        // Falling edge of bright marks the end of a line.
        if (bright_q && !bright_in) begin
            if (x_q != X_LINE) begin
                line_err_d = 1'b1;
            end
            x_d = '0;
        end

        // Frame start overrides any increment; frame_done above is unaffected.
        if (vs_fall) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            addr_q       <= '0;
            x_q          <= '0;
            bright_q     <= 1'b0;
            v_sync_q     <= 1'b1;
            rd_en_q      <= 1'b0;
            fb_addr_q    <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            hs_d1_q      <= 1'b1;
            hs_d2_q      <= 1'b1;
            vs_d1_q      <= 1'b1;
            vs_d2_q      <= 1'b1;
            br_d1_q      <= 1'b0;
            br_d2_q      <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            x_q          <= x_d;
            bright_q     <= bright_in;
            v_sync_q     <= v_sync_in;
            rd_en_q      <= rd_en_d;
            fb_addr_q    <= fb_addr_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            hs_d1_q      <= h_sync_in;
            hs_d2_q      <= hs_d1_q;
            vs_d1_q      <= v_sync_in;
            vs_d2_q      <= vs_d1_q;
            br_d1_q      <= bright_in;
            br_d2_q      <= br_d1_q;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Pixel index travels alongside bright so the bar lines up with its pixel.
    logic [7:0] x_d1_q, x_d2_q;
    logic [2:0] bar;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            x_d1_q <= '0;
            x_d2_q <= '0;
        end else begin
            x_d1_q <= x_q;
            x_d2_q <= x_d1_q;
        end
    end

    assign bar = 3'(x_d2_q / 8'd20);
`endif

    // fb_data arrives together with stage-2 bright, so colour is a gated decode of it.
    always_comb begin
        vga_r = 4'h0;
        vga_g = 4'h0;
        vga_b = 4'h0;
        if (br_d2_q) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                vga_r = {4{bar[2]}};
                vga_g = {4{bar[1]}};
                vga_b = {4{bar[0]}};
            end else begin
                vga_r = {fb_data[7:5], fb_data[7]};
                vga_g = {fb_data[4:2], fb_data[4]};
                vga_b = {fb_data[1:0], fb_data[1:0]};
            end
`else
            vga_r = {fb_data[7:5], fb_data[7]};
            vga_g = {fb_data[4:2], fb_data[4]};
            vga_b = {fb_data[1:0], fb_data[1:0]};
`endif
        end
    end

    assign fb_rd_en   = rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign h_sync     = hs_d2_q;
    assign v_sync     = vs_d2_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: table of RGB332 decode vectors plus
// hand-written sequences for line length, frame wrap, v_sync restart and reset.
module tb_vga_pixel_fetch;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        h_sync_in, v_sync_in, bright_in;
    logic        fb_rd_en;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        h_sync, v_sync, frame_done, line_err;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    logic [7:0]  fb_const = 8'h00;
    int          n_pass = 0;
    int          n_total = 0;
    int          fd_cnt = 0;
    int          fd_addr = -1;

    typedef struct {
        logic [7:0] dat;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs [8];

    vga_pixel_fetch #(.H_RES(160), .V_RES(120), .ADDR_W(15)) dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .bright_in  (bright_in),
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .frame_done (frame_done),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .line_err   (line_err)
    );

    always #20 clk_25 = ~clk_25;

    // Framebuffer model: synchronous read, one cycle of latency.
    always @(posedge clk_25) begin
        if (fb_rd_en) fb_data <= fb_const;
    end

    always @(negedge clk_25) begin
        if (frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_addr = int'(fb_addr);
        end
    end

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bright_in = 1'b0;
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_bright(input int n);
        bright_in = 1'b1;
        repeat (n) step();
        bright_in = 1'b0;
    endtask

    task automatic run_line_blank(input int n, input int blank);
        run_bright(n);
        repeat (blank) step();
    endtask

    initial begin
        // RGB332 -> 4:4:4: R={d7..5,d7}, G={d4..2,d4}, B={d1..0,d1..0}
        vecs[0] = '{8'hFF, 4'hF, 4'hF, 4'hF};
        vecs[1] = '{8'hA9, 4'hB, 4'h4, 4'h5};  // 101_010_01: G={010,0}=4
        vecs[2] = '{8'h00, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{8'hE0, 4'hF, 4'h0, 4'h0};
        vecs[4] = '{8'h1C, 4'h0, 4'hF, 4'h0};
        vecs[5] = '{8'h03, 4'h0, 4'h0, 4'hF};
        vecs[6] = '{8'h49, 4'h4, 4'h4, 4'h5};
        vecs[7] = '{8'h92, 4'h9, 4'h9, 4'hA};

        // Reset state
        do_reset();
        chk("rst_rd_en", int'(fb_rd_en), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_hsync", int'(h_sync), 1);
        chk("rst_vsync", int'(v_sync), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_line_err", int'(line_err), 0);

        // One full white line: addresses 0..159, colour two edges behind input
        fb_const  = 8'hFF;
        bright_in = 1'b1;
        for (int i = 0; i < 160; i++) begin
            step();
            chk("line_addr", int'(fb_addr), i);
            chk("line_rd_en", int'(fb_rd_en), 1);
            chk("line_rgb", int'({vga_r, vga_g, vga_b}), (i == 0) ? 0 : 12'hFFF);
        end
        bright_in = 1'b0;
        step();
        chk("blank0_rd_en", int'(fb_rd_en), 0);
        chk("blank0_addr_hold", int'(fb_addr), 159);
        chk("blank0_rgb_last", int'({vga_r, vga_g, vga_b}), 12'hFFF);
        step();
        chk("blank1_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("line_ok_no_err", int'(line_err), 0);

        // h_sync delayed by two edges
        h_sync_in = 1'b0;
        step();
        chk("hs_lat1", int'(h_sync), 1);
        step();
        chk("hs_lat2", int'(h_sync), 0);
        h_sync_in = 1'b1;
        step();
        chk("hs_rise1", int'(h_sync), 0);
        step();
        chk("hs_rise2", int'(h_sync), 1);

        // Decode table
        foreach (vecs[k]) begin
            do_reset();
            fb_const  = vecs[k].dat;
            bright_in = 1'b1;
            step();
            step();
            chk($sformatf("rgb_vec%0d", k), int'({vga_r, vga_g, vga_b}),
                int'({vecs[k].r, vecs[k].g, vecs[k].b}));
            bright_in = 1'b0;
            step();
        end

        // Full frame: one frame_done at 19199, then wrap to 0
        do_reset();
        fb_const = 8'h5A;
        fd_cnt   = 0;
        fd_addr  = -1;
        for (int l = 0; l < 120; l++) run_line_blank(160, 4);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_done_addr", fd_addr, 19199);
        chk("frame_no_line_err", int'(line_err), 0);
        bright_in = 1'b1;
        step();
        chk("frame_wrap_addr", int'(fb_addr), 0);
        bright_in = 1'b0;
        step();

        // v_sync falling edge after 500 pixels restarts addressing
        do_reset();
        fd_cnt = 0;
        for (int l = 0; l < 3; l++) run_line_blank(160, 4);
        run_line_blank(20, 1);
        chk("vs_pre_addr", int'(fb_addr), 499);
        v_sync_in = 1'b0;
        step();
        chk("vs_lat1", int'(v_sync), 1);
        step();
        chk("vs_lat2", int'(v_sync), 0);
        v_sync_in = 1'b1;
        step();
        step();
        bright_in = 1'b1;
        step();
        chk("vs_restart_addr", int'(fb_addr), 0);
        bright_in = 1'b0;
        step();
        chk("vs_no_frame_done", fd_cnt, 0);

        // Short line sets line_err; it stays set through good lines
        do_reset();
        run_line_blank(159, 2);
        chk("short_line_err", int'(line_err), 1);
        run_line_blank(160, 2);
        run_line_blank(160, 2);
        chk("line_err_sticky", int'(line_err), 1);
        do_reset();
        chk("line_err_cleared", int'(line_err), 0);
        run_line_blank(161, 2);
        chk("long_line_err", int'(line_err), 1);

        // Reset in the middle of a line: partial line not flagged
        do_reset();
        bright_in = 1'b1;
        repeat (50) step();
        reset = 1'b1;
        step();
        chk("midrst_rd_en", int'(fb_rd_en), 0);
        reset = 1'b0;
        step();
        chk("midrst_addr", int'(fb_addr), 0);
        repeat (159) step();
        bright_in = 1'b0;
        step();
        step();
        chk("midrst_no_err", int'(line_err), 0);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars: bar = pixel/20; R,G,B follow bar bits 2,1,0
        do_reset();
        fb_const  = 8'h00;
        test_mode = 1'b1;
        bright_in = 1'b1;
        for (int i = 0; i < 160; i++) begin
            step();
            if (i == 1)   chk("bar_px0", int'({vga_r, vga_g, vga_b}), 0);
            if (i == 46)  chk("bar_px45", int'({vga_r, vga_g, vga_b}), 12'h0F0);
            if (i == 150) chk("bar_px149", int'({vga_r, vga_g, vga_b}), 12'hFFF);
        end
        bright_in = 1'b0;
        step();
        chk("bar_px159", int'({vga_r, vga_g, vga_b}), 12'hFFF);
        chk("bar_reads", int'(fb_addr), 159);
        test_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
